uart_bus_regfile: RTL and testbench

UART_BUS_REGFILE -- requirements
Module: uart_bus_regfile

---
 rtl/uart_regfile_pkg.sv | 22 ++
 rtl/uart_regfile_gnt.sv | 39 +++
 rtl/uart_bus_regfile.sv | 133 +++++++++++++
 tb/tb_uart_bus_regfile.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_regfile_pkg.sv
// Package for the UART bus register file.
// Holds the register offsets, the default ID value and the grant FSM state
// encoding shared by uart_regfile_gnt and uart_bus_regfile.
package uart_regfile_pkg;

  localparam logic [2:0] OFF_ID       = 3'd0;
  localparam logic [2:0] OFF_CTRL     = 3'd1;
  localparam logic [2:0] OFF_SCRATCH0 = 3'd2;
  localparam logic [2:0] OFF_SCRATCH1 = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
  localparam logic [2:0] OFF_EVENT    = 3'd5;
  localparam logic [2:0] OFF_WR_CNT   = 3'd6;
  localparam logic [2:0] OFF_IRQ_MASK = 3'd7;

  localparam logic [7:0] ID_DEFAULT = 8'hA5;

  // Grant FSM encoding, kept as plain constants for legacy tools.
  typedef logic [0:0] gnt_state_t;
  localparam gnt_state_t GNT_IDLE    = 1'b0;
  localparam gnt_state_t GNT_GRANTED = 1'b1;

endpackage

// File: rtl/uart_regfile_gnt.sv
// Bus grant FSM for the UART register file.
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous active-high reset, forces IDLE
//   int_req - bus access request from the master
//   int_gnt - grant, high exactly while the FSM is in GRANTED
module uart_regfile_gnt
  import uart_regfile_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic int_req,
  output logic int_gnt
);

  gnt_state_t state;
  gnt_state_t state_next;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      GNT_IDLE:    if (int_req)  state_next = GNT_GRANTED;
      GNT_GRANTED: if (!int_req) state_next = GNT_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) state <= GNT_IDLE;
    else       state <= state_next;
  end

  // Decoded from state, so the grant drops on the same edge as reset.
  assign int_gnt = (state == GNT_GRANTED);

endmodule

// File: rtl/uart_bus_regfile.sv
// UART bus register file: an 8-byte register window on a simple strobe bus.
// Optional feature macro: UART_REGFILE_IRQ_EN (adds IRQ_MASK at offset 7 and
// a registered interrupt output; without it offset 7 reads zero, irq is 0).
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   int_address/int_wr_data - bus address and write data
//   int_write/int_read      - single-cycle strobes, honoured only when granted
//   int_rd_data             - registered read data, holds until next read
//   int_req/int_gnt         - bus request and grant
//   status_in               - hardware status, registered into STATUS
//   event_in                - per-bit event pulses, accumulated into EVENT
//   ctrl_out                - CTRL register contents
//   irq                     - interrupt request
module uart_bus_regfile
  import uart_regfile_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [7:0]  ID_VALUE  = ID_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] int_address,
  input  logic [7:0]  int_wr_data,
  input  logic        int_write,
  input  logic        int_read,
  output logic [7:0]  int_rd_data,
  input  logic        int_req,
  output logic        int_gnt,
  input  logic [7:0]  status_in,
  input  logic [7:0]  event_in,
  output logic [7:0]  ctrl_out,
  output logic        irq
);

  logic       hit;
  logic [2:0] offset;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] w1c_mask;
  logic [7:0] rd_mux;
  logic [7:0] mask_rd;

  logic [7:0] ctrl_q;
  logic [7:0] scratch0_q;
  logic [7:0] scratch1_q;
  logic [7:0] status_q;
  logic [7:0] event_q;
  logic [7:0] wr_cnt_q;
  logic [7:0] rd_data_q;

  uart_regfile_gnt u_gnt (
    .clock   (clock),
    .reset   (reset),
    .int_req (int_req),
    .int_gnt (int_gnt)
  );

  assign hit    = (int_address[15:3] == BASE_ADDR[15:3]);
  assign offset = int_address[2:0];

  // A write beats a simultaneous read; the read is dropped entirely, even
  // when the write itself falls outside the window.
  assign wr_en = int_gnt & int_write & hit;
  assign rd_en = int_gnt & int_read & ~int_write;

  assign w1c_mask = (wr_en && offset == OFF_EVENT) ? int_wr_data : 8'h00;

  always_comb begin
    rd_mux = 8'h00;
    case (offset)
      OFF_ID:       rd_mux = ID_VALUE;
      OFF_CTRL:     rd_mux = ctrl_q;
      OFF_SCRATCH0: rd_mux = scratch0_q;
      OFF_SCRATCH1: rd_mux = scratch1_q;
      OFF_STATUS:   rd_mux = status_q;
      OFF_EVENT:    rd_mux = event_q;     // pre-update value on an event race
      OFF_WR_CNT:   rd_mux = wr_cnt_q;
      OFF_IRQ_MASK: rd_mux = mask_rd;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q     <= 8'h00;
      scratch0_q <= 8'h00;
      scratch1_q <= 8'h00;
      status_q   <= 8'h00;
      event_q    <= 8'h00;
      wr_cnt_q   <= 8'h00;
      rd_data_q  <= 8'h00;
    end else begin
      status_q <= status_in;
      // Set wins: new events are OR-ed in after the write-1-to-clear.
      event_q  <= (event_q & ~w1c_mask) | event_in;
      if (wr_en) begin
        // Every in-window write counts, RO targets included; wraps at 8 bits.
        wr_cnt_q <= wr_cnt_q + 8'd1;
        case (offset)
          OFF_CTRL:     ctrl_q     <= int_wr_data;
          OFF_SCRATCH0: scratch0_q <= int_wr_data;
          OFF_SCRATCH1: scratch1_q <= int_wr_data;
          default: ;
        endcase
      end
      if (rd_en) rd_data_q <= hit ? rd_mux : 8'h00;
    end
  end

`ifdef UART_REGFILE_IRQ_EN
  logic [7:0] irq_mask_q;
  logic       irq_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_mask_q <= 8'h00;
      irq_q      <= 1'b0;
    end else begin
      if (wr_en && offset == OFF_IRQ_MASK) irq_mask_q <= int_wr_data;
      irq_q <= |(event_q & irq_mask_q);
    end
  end

  assign mask_rd = irq_mask_q;
  assign irq     = irq_q;
`else
  assign mask_rd = 8'h00;
  assign irq     = 1'b0;
`endif

  assign int_rd_data = rd_data_q;
  assign ctrl_out    = ctrl_q;

endmodule

// File: tb/tb_uart_bus_regfile.sv
// Self-checking bench for uart_bus_regfile: directed scenarios plus random
// traffic, checked by a scoreboard fed from a register-level reference model.
module tb_uart_bus_regfile;

  localparam logic [15:0] BASE = 16'h0000;
  localparam logic [7:0]  ID   = 8'hA5;
  localparam logic [15:0] OUT_ADDR = 16'h1230;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] int_address = '0;
  logic [7:0]  int_wr_data = '0;
  logic        int_write = 1'b0;
  logic        int_read = 1'b0;
  logic [7:0]  int_rd_data;
  logic        int_req = 1'b0;
  logic        int_gnt;
  logic [7:0]  status_in = '0;
  logic [7:0]  event_in = '0;
  logic [7:0]  ctrl_out;
  logic        irq;

  uart_bus_regfile #(.BASE_ADDR(BASE), .ID_VALUE(ID)) dut (
    .clock       (clock),
    .reset       (reset),
    .int_address (int_address),
    .int_wr_data (int_wr_data),
    .int_write   (int_write),
    .int_read    (int_read),
    .int_rd_data (int_rd_data),
    .int_req     (int_req),
    .int_gnt     (int_gnt),
    .status_in   (status_in),
    .event_in    (event_in),
    .ctrl_out    (ctrl_out),
    .irq         (irq)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  localparam int K_GNT = 0, K_RD = 1, K_CTRL = 2, K_IRQ = 3;
  typedef struct {
    int         due;
    int         kind;
    string      name;
    logic [7:0] exp;
  } exp_t;
  exp_t sb[$];
  int   drv_cyc = 0;

  // Reference model: the register window as an array indexed by offset.
  // Index 4 = STATUS, 5 = EVENT, 6 = WR_CNT, 7 = IRQ_MASK; 0 is constant ID.
  logic [7:0] m_reg [8];
  logic       m_gnt = 1'b0;
  logic [7:0] m_rd  = 8'h00;
  logic       m_irq = 1'b0;

  function automatic logic [7:0] m_read(int off);
    if (off == 0) return ID;
`ifndef UART_REGFILE_IRQ_EN
    if (off == 7) return 8'h00;
`endif
    return m_reg[off];
  endfunction

  task automatic push(int kind, string name, logic [7:0] exp);
    exp_t e;
    e.due = drv_cyc + 1; e.kind = kind; e.name = name; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic model_step(logic rst, logic req, logic [15:0] addr, logic [7:0] wd,
                            logic wr, logic rd, logic [7:0] st, logic [7:0] ev);
    bit         in_win = (addr[15:3] == BASE[15:3]);
    int         off    = int'(addr[2:0]);
    bit         wr_ok, rd_ok;
    logic [7:0] clr;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
      m_gnt = 1'b0; m_rd = 8'h00; m_irq = 1'b0;
      return;
    end
    wr_ok = wr && m_gnt && in_win;
    rd_ok = rd && m_gnt && !wr;
    if (rd_ok) m_rd = in_win ? m_read(off) : 8'h00;
`ifdef UART_REGFILE_IRQ_EN
    m_irq = |(m_reg[5] & m_reg[7]);
`else
    m_irq = 1'b0;
`endif
    clr = (wr_ok && off == 5) ? wd : 8'h00;
    m_reg[5] = (m_reg[5] & ~clr) | ev;
    m_reg[4] = st;
    if (wr_ok) begin
      m_reg[6] = m_reg[6] + 8'd1;
      if (off >= 1 && off <= 3) m_reg[off] = wd;
`ifdef UART_REGFILE_IRQ_EN
      if (off == 7) m_reg[7] = wd;
`endif
    end
    m_gnt = req;
  endtask

  // Drive one cycle of inputs, advance the model and queue its predictions.
  task automatic drive(logic rst, logic req, logic [15:0] addr, logic [7:0] wd,
                       logic wr, logic rd, logic [7:0] ev);
    logic [7:0] st = 8'($urandom_range(0, 255));
    @(posedge clock); #1;
    reset = rst; int_req = req; int_address = addr; int_wr_data = wd;
    int_write = wr; int_read = rd; status_in = st; event_in = ev;
    drv_cyc = cyc;
    model_step(rst, req, addr, wd, wr, rd, st, ev);
    push(K_GNT,  "gnt",     {7'd0, m_gnt});
    push(K_RD,   "rd_data", m_rd);
    push(K_CTRL, "ctrl",    m_reg[1]);
    push(K_IRQ,  "irq",     {7'd0, m_irq});
  endtask

  task automatic idle(logic req, logic [7:0] ev = 8'h00);
    drive(1'b0, req, BASE, 8'h00, 1'b0, 1'b0, ev);
  endtask
  task automatic wr(logic [2:0] off, logic [7:0] d, logic [7:0] ev = 8'h00);
    drive(1'b0, 1'b1, BASE + {13'd0, off}, d, 1'b1, 1'b0, ev);
  endtask
  task automatic rd(logic [2:0] off);
    drive(1'b0, 1'b1, BASE + {13'd0, off}, 8'h00, 1'b0, 1'b1, 8'h00);
  endtask

  // Monitor: compares every queued expectation at its due cycle.
  exp_t       mon_e;
  logic [7:0] mon_act;
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        K_GNT:   mon_act = {7'd0, int_gnt};
        K_RD:    mon_act = int_rd_data;
        K_CTRL:  mon_act = ctrl_out;
        default: mon_act = {7'd0, irq};
      endcase
      checks = checks + 1;
      if (mon_e.due != cyc || mon_act !== mon_e.exp) begin
        errors = errors + 1;
        $display("FAIL %s cycle %0d (due %0d): got %h expected %h",
                 mon_e.name, cyc, mon_e.due, mon_act, mon_e.exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    drive(1'b1, 1'b0, BASE, 8'h00, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, BASE, 8'h00, 1'b0, 1'b0, 8'h00);
    push(K_GNT, "reset_gnt", 8'h00);
    push(K_RD, "reset_rd", 8'h00);
    push(K_CTRL, "reset_ctrl", 8'h00);
    push(K_IRQ, "reset_irq", 8'h00);

    // Grant timing; the ungranted write in the request cycle is ignored.
    wr(3'd1, 8'h77);
    push(K_GNT, "gnt_rise", 8'h01);
    push(K_CTRL, "ungranted_wr", 8'h00);
    for (int i = 1; i < 5; i++) idle(1'b1);
    idle(1'b0);
    push(K_GNT, "gnt_fall", 8'h00);
    idle(1'b1);

    // RW and RO behaviour.
    wr(3'd1, 8'h3C);
    push(K_CTRL, "ctrl_wr", 8'h3C);
    rd(3'd1);
    push(K_RD, "ctrl_rd", 8'h3C);
    wr(3'd0, 8'hFF);
    rd(3'd0);
    push(K_RD, "id_ro", ID);
    rd(3'd6);
    push(K_RD, "wr_cnt_ro_counted", 8'h02);

    // Write-1-to-clear racing a new event: set wins.
    idle(1'b1, 8'h05);
    wr(3'd5, 8'h05, 8'h01);
    rd(3'd5);
    push(K_RD, "w1c_race", 8'h01);

`ifdef UART_REGFILE_IRQ_EN
    wr(3'd7, 8'h02);
    idle(1'b1, 8'h02);
    idle(1'b1);
    push(K_IRQ, "irq_set", 8'h01);
    wr(3'd5, 8'h02);
    idle(1'b1);
    push(K_IRQ, "irq_clear", 8'h00);
`else
    wr(3'd7, 8'h02);
    rd(3'd7);
    push(K_RD, "mask_absent", 8'h00);
    idle(1'b1, 8'h02);
    idle(1'b1);
    push(K_IRQ, "irq_tied", 8'h00);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 4) != 0) ? BASE + 16'($urandom_range(0, 7))
                                      : 16'($urandom_range(0, 65535));
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), a,
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00);
    end

    // Write counter wrap.
    drive(1'b1, 1'b1, BASE, 8'h00, 1'b0, 1'b0, 8'h00);
    idle(1'b1);
    for (int i = 0; i < 256; i++) wr(3'd2, 8'($urandom_range(0, 255)));
    rd(3'd6);
    push(K_RD, "wr_cnt_256", 8'h00);
    wr(3'd3, 8'h11);
    rd(3'd6);
    push(K_RD, "wr_cnt_257", 8'h01);
    drive(1'b0, 1'b1, OUT_ADDR, 8'h55, 1'b1, 1'b0, 8'h00);
    rd(3'd6);
    push(K_RD, "wr_cnt_out_of_window", 8'h01);
    drive(1'b0, 1'b1, OUT_ADDR, 8'h00, 1'b0, 1'b1, 8'h00);
    push(K_RD, "rd_out_of_window", 8'h00);

    // Reset in the middle of a granted write.
    rd(3'd0);
    push(K_RD, "pre_reset_rd", ID);
    drive(1'b1, 1'b1, BASE + 16'd2, 8'h99, 1'b1, 1'b0, 8'h00);
    push(K_GNT, "reset_mid_gnt", 8'h00);
    push(K_RD, "reset_mid_rd", 8'h00);
    idle(1'b1);
    rd(3'd2);
    push(K_RD, "reset_mid_scratch0", 8'h00);

    idle(1'b0);
    idle(1'b0);
    @(posedge clock);
    @(posedge clock);
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
